// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU among NREQ requesters.
// One op in flight: IDLE grants and registers operands, EXEC lets the ALU
// settle, RESP holds the tagged result until the consumer accepts it.
module alu_rr_sched #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 16,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_op,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [3:0]           alu_op,
  input  logic [XLEN-1:0]      alu_s,
  input  logic [3:0]           alu_nzvc,
  input  logic                 alu_hata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_s,
  output logic [3:0]           rsp_nzvc,
  output logic                 rsp_hata,
  output logic                 busy,
  output logic [CNTW-1:0]      op_count,
  output logic [CNTW-1:0]      err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;

  // (p + k) mod NREQ without relying on NREQ being a power of two
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int unsigned k);
    int unsigned sum;
    sum = 32'(p) + k;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  // first valid requester at or after ptr, in circular order
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[wrap_add(ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_add(ptr, k);
      end
    end
  end

  // one-hot grant, only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (!rst && (state == IDLE) && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // scheduler state, operand/result registers and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      rsp_nzvc  <= '0;
      rsp_hata  <= 1'b0;
      busy      <= 1'b0;
      op_count  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            alu_a  <= req_a[32'(gnt_idx)*XLEN +: XLEN];
            alu_b  <= req_b[32'(gnt_idx)*XLEN +: XLEN];
            alu_op <= req_op[32'(gnt_idx)*4 +: 4];
            rsp_id <= gnt_idx;
            ptr    <= wrap_add(gnt_idx, 1);
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_s     <= alu_s;
          rsp_nzvc  <= alu_nzvc;
          rsp_hata  <= alu_hata;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            if (op_count != '1) op_count <= op_count + CNTW'(1);
            if (rsp_hata && (err_count != '1)) err_count <= err_count + CNTW'(1);
            state     <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: behavioural ALU attached to the DUT, directed cases
// followed by randomized traffic checked against a transaction-level model.
module tb_alu_rr_sched;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned CNTW = 4;
  localparam int unsigned IDW  = 2;
  localparam int          CMAX = (1 << CNTW) - 1;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [NREQ*4-1:0]    req_op;
  logic [XLEN-1:0]      alu_a;
  logic [XLEN-1:0]      alu_b;
  logic [3:0]           alu_op;
  logic [XLEN-1:0]      alu_s;
  logic [3:0]           alu_nzvc;
  logic                 alu_hata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_s;
  logic [3:0]           rsp_nzvc;
  logic                 rsp_hata;
  logic                 busy;
  logic [CNTW-1:0]      op_count;
  logic [CNTW-1:0]      err_count;

  alu_rr_sched #(.XLEN(XLEN), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_s(alu_s), .alu_nzvc(alu_nzvc), .alu_hata(alu_hata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_nzvc(rsp_nzvc), .rsp_hata(rsp_hata),
    .busy(busy), .op_count(op_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic [3:0]  nzvc;
    logic        hata;
  } alu_res_t;

  // reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 pass b, rest illegal
  function automatic alu_res_t alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    alu_res_t   r;
    logic [32:0] w;
    logic        v;
    logic        c;
    r = '0;
    v = 1'b0;
    c = 1'b0;
    w = '0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r.s = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r.s[31] != a[31]);
      end
      4'd1: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.s = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r.s[31] != a[31]);
      end
      4'd2: r.s = a & b;
      4'd3: r.s = a | b;
      4'd4: r.s = a ^ b;
      4'd5: r.s = a << b[4:0];
      4'd6: r.s = a >> b[4:0];
      4'd7: r.s = 32'($signed(a) >>> b[4:0]);
      4'd8: r.s = b;
      default: r.hata = 1'b1;
    endcase
    r.nzvc = r.hata ? 4'b0000 : {r.s[31], (r.s == 32'd0), v, c};
    return r;
  endfunction

  alu_res_t alu_now;
  assign alu_now  = alu_ref(alu_a, alu_b, alu_op);
  assign alu_s    = alu_now.s;
  assign alu_nzvc = alu_now.nzvc;
  assign alu_hata = alu_now.hata;

  int total = 0;
  int bad   = 0;

  // transaction-level model state
  int          m_ptr  = 0;
  int          m_ops  = 0;
  int          m_errs = 0;
  logic [31:0] pa  [NREQ];
  logic [31:0] pb  [NREQ];
  logic [3:0]  pop [NREQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int sat_inc(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*XLEN +: XLEN] = pa[i];
      req_b[i*XLEN +: XLEN] = pb[i];
      req_op[i*4 +: 4]      = pop[i];
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*XLEN +: XLEN] = $urandom;
      req_b[i*XLEN +: XLEN] = $urandom;
      req_op[i*4 +: 4]      = 4'($urandom);
    end
    req_valid = 4'($urandom);
  endtask

  task automatic chk_rsp(input int g, input alu_res_t e);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, g);
    check("rsp_s", rsp_s, e.s);
    check("rsp_nzvc", rsp_nzvc, e.nzvc);
    check("rsp_hata", rsp_hata, e.hata);
    check("resp_ready_low", req_ready, 0);
    check("resp_op_count", op_count, m_ops);
    check("resp_busy", busy, 1);
  endtask

  // one IDLE cycle with valids v; if granted, follow the op through EXEC and
  // RESP, stalling the consumer for 'stall' cycles. Entered and left at a negedge.
  task automatic issue(input logic [NREQ-1:0] v, input int stall);
    int       g;
    alu_res_t e;
    req_valid = v;
    drive_payload();
    rsp_ready = (stall == 0);
    #1;
    g = pick(v);
    check("grant", req_ready, (g < 0) ? 0 : (1 << g));
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    if (g < 0) return;
    m_ptr = (g + 1) % NREQ;
    e = alu_ref(pa[g], pb[g], pop[g]);
    scramble();
    check("exec_busy", busy, 1);
    check("exec_ready", req_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    check("alu_a", alu_a, pa[g]);
    check("alu_b", alu_b, pb[g]);
    check("alu_op", alu_op, pop[g]);
    @(negedge clk);
    for (int s = 0; s < stall; s++) begin
      scramble();
      chk_rsp(g, e);
      @(negedge clk);
    end
    chk_rsp(g, e);
    rsp_ready = 1'b1;
    @(negedge clk);
    m_ops = sat_inc(m_ops);
    if (e.hata) m_errs = sat_inc(m_errs);
    check("done_rsp_valid", rsp_valid, 0);
    check("done_busy", busy, 0);
    check("op_count", op_count, m_ops);
    check("err_count", err_count, m_errs);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_op_count", op_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_s", rsp_s, 0);
    check("rst_rsp_id", rsp_id, 0);
    rst = 1'b0;
    req_valid = '0;
    m_ptr = 0;
    m_ops = 0;
    m_errs = 0;
  endtask

  task automatic legal_payloads();
    for (int i = 0; i < NREQ; i++) begin
      pa[i]  = $urandom;
      pb[i]  = $urandom;
      pop[i] = 4'($urandom_range(0, 8));
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    legal_payloads();
    do_reset();

    // single add from requester 2: 5 + 3 = 8, flags clear
    pa[2] = 32'd5; pb[2] = 32'd3; pop[2] = 4'd0;
    issue(4'b0100, 0);
    check("t1_rsp_s", rsp_s, 32'd8);
    check("t1_nzvc", rsp_nzvc, 4'b0000);
    check("t1_op_count", op_count, 1);

    // fairness: all requesters pending from reset, eight ops
    do_reset();
    for (int k = 0; k < 8; k++) begin
      legal_payloads();
      issue(4'hF, 0);
    end

    // backpressure: consumer stalls ten cycles
    legal_payloads();
    issue(4'b1001, 10);

    // error path: illegal opcode reported through hata
    legal_payloads();
    pop[1] = 4'hB;
    issue(4'b0010, 0);
    check("t4_hata", rsp_hata, 1);

    // reset in EXEC aborts the op and returns the pointer to 0
    legal_payloads();
    issue(4'b0010, 0);
    req_valid = 4'hF;
    drive_payload();
    @(negedge clk);
    check("t5_exec_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", req_ready, 0);
    check("t5_op_count", op_count, 0);
    check("t5_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_ops = 0;
    m_errs = 0;
    issue(4'b1010, 0);
    check("t5_regrant_id", rsp_id, 1);

    // random traffic, long enough to saturate both counters
    for (int n = 0; n < 90; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        pa[i]  = $urandom;
        pb[i]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        pop[i] = 4'($urandom_range(0, 15));
      end
      issue(4'($urandom), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 1)));
    end
    check("sat_op_count", op_count, CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
